// File: rtl/led_bounce_pkg.sv
// led_bounce_pkg: phase encoding and thermometer helper shared by the LED
// bounce controller.
`timescale 1ns/1ps
package led_bounce_pkg;

  // Widest bar the controller supports; therm() builds codes at this width.
  localparam int unsigned THERM_W = 64;

  // Phase encoding; the numeric values are visible on the debug state port.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UP_FULL   = 3'd1,
    DOWN_P1   = 3'd2,
    UP_P2     = 3'd3,
    DOWN_ZERO = 3'd4,
    UP_P3     = 3'd5,
    DOWN_FIN  = 3'd6
  } led_state_e;

  // Thermometer code: the lowest 'level' bits set, lit from bit 0.
  function automatic logic [THERM_W-1:0] therm(input logic [6:0] level);
    logic [THERM_W-1:0] code;
    code = '0;
    for (int unsigned i = 0; i < THERM_W; i++) begin
      if (32'(level) > i) begin
        code[i] = 1'b1;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/led_bounce_ctrl_tick.sv
// led_tick_gen: step-rate prescaler. Counts 0..TICK_DIV-1 while enabled and
// flags the last count as a step tick; held at zero while disabled.
`timescale 1ns/1ps
module led_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Free-running divider while enabled, cleared whenever the block is idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/led_bounce_ctrl.sv
// led_bounce_ctrl: drives an N-wide thermometer LED bar through a six-phase
// rise/fall sequence, with flick-driven kickback at the low turn points.
// Build option: define LED_BOUNCE_FLICK_SYNC_EN to pass flick through a
// 2-flop synchroniser before any use (all flick responses 2 clocks later).
`timescale 1ns/1ps
module led_bounce_ctrl
  import led_bounce_pkg::*;
#(
  parameter int N        = 16,
  parameter int P_LO     = 5,
  parameter int P_HI     = 10,
  parameter int TICK_DIV = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flick,
  output logic [N-1:0] led,
  output logic [2:0]   state,
  output logic         busy,
  output logic         done
);

  localparam int LW = $clog2(N + 1);
  localparam logic [LW-1:0] LV_ZERO = '0;
  localparam logic [LW-1:0] LV_N    = LW'(N);
  localparam logic [LW-1:0] LV_LO   = LW'(P_LO);
  localparam logic [LW-1:0] LV_HI   = LW'(P_HI);

  led_state_e    state_q, state_nxt;
  logic [LW-1:0] level_q, level_nxt;
  logic [N-1:0]  led_q, led_nxt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;
  logic          flick_s;
  logic          tick;

  // Per-phase stepping description, decoded from the current phase.
  logic          asc;
  logic [LW-1:0] target;
  led_state_e    after;
  led_state_e    kick_to;
  logic          can_kick;
  logic          stepping;
  logic [LW-1:0] stepped;

`ifdef LED_BOUNCE_FLICK_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchroniser; every flick decision uses the second stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], flick};
    end
  end

  assign flick_s = sync_q[1];
`else
  assign flick_s = flick;
`endif

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy_q),
    .tick  (tick)
  );

  // Decode the active phase into direction, target level and successors.
  always_comb begin
    asc      = 1'b1;
    target   = LV_N;
    after    = IDLE;
    kick_to  = IDLE;
    can_kick = 1'b0;
    stepping = 1'b1;
    case (state_q)
      UP_FULL: begin
        asc    = 1'b1;
        target = LV_N;
        after  = DOWN_P1;
      end
      DOWN_P1: begin
        asc      = 1'b0;
        target   = LV_LO;
        after    = UP_P2;
        kick_to  = UP_FULL;
        can_kick = 1'b1;
      end
      UP_P2: begin
        asc    = 1'b1;
        target = LV_HI;
        after  = DOWN_ZERO;
      end
      DOWN_ZERO: begin
        asc      = 1'b0;
        target   = LV_ZERO;
        after    = UP_P3;
        kick_to  = UP_P2;
        can_kick = 1'b1;
      end
      UP_P3: begin
        asc    = 1'b1;
        target = LV_LO;
        after  = DOWN_FIN;
      end
      DOWN_FIN: begin
        asc      = 1'b0;
        target   = LV_ZERO;
        after    = IDLE;
        kick_to  = UP_P3;
        can_kick = 1'b1;
      end
      default: begin
        stepping = 1'b0;
      end
    endcase
    stepped = asc ? (level_q + LW'(1)) : (level_q - LW'(1));
  end

  // Next phase, level and done pulse; the phase change lands on the same
  // edge as the step that reaches the target.
  always_comb begin
    state_nxt = state_q;
    level_nxt = level_q;
    done_nxt  = 1'b0;
    if (state_q == IDLE) begin
      if (flick_s) begin
        state_nxt = UP_FULL;
        level_nxt = '0;
      end
    end else if (!stepping) begin
      state_nxt = IDLE;
      level_nxt = '0;
    end else if (tick) begin
      level_nxt = stepped;
      if (stepped == target) begin
        if (can_kick && flick_s) begin
          state_nxt = kick_to;
        end else begin
          state_nxt = after;
          done_nxt  = (after == IDLE);
        end
      end
    end
    busy_nxt = (state_nxt != IDLE);
    led_nxt  = N'(therm(7'(level_nxt)));
  end

  // Registered phase, level and all outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      level_q <= level_nxt;
      led_q   <= led_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  assign led   = led_q;
  assign state = state_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_led_bounce_ctrl.sv
// tb_led_bounce_ctrl: scoreboard bench for led_bounce_ctrl. Two instances run
// side by side (default parameters and a small prescaled bar); a cycle model
// pushes expected outputs when stimulus is driven, the monitor pops them
// after each rising edge.
`timescale 1ns/1ps
module tb_led_bounce_ctrl;

  localparam int N0 = 16, LO0 = 5, HI0 = 10, DV0 = 1;
  localparam int N1 = 8,  LO1 = 2, HI1 = 5,  DV1 = 4;
`ifdef LED_BOUNCE_FLICK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fl0 = 1'b0, fl1 = 1'b0;
  logic [N0-1:0] led0;
  logic [N1-1:0] led1;
  logic [2:0]    st0, st1;
  logic          bz0, bz1, dn0, dn1;

  always #5 clk = ~clk;

  led_bounce_ctrl #(.N(N0), .P_LO(LO0), .P_HI(HI0), .TICK_DIV(DV0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flick(fl0),
    .led(led0), .state(st0), .busy(bz0), .done(dn0)
  );

  led_bounce_ctrl #(.N(N1), .P_LO(LO1), .P_HI(HI1), .TICK_DIV(DV1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flick(fl1),
    .led(led1), .state(st1), .busy(bz1), .done(dn1)
  );

  typedef struct {
    int ph; int lvl; int cnt; bit done; bit s1; bit s2;
  } mdl_t;

  typedef struct {
    logic [63:0] led0, led1, st0, st1, bz0, bz1, dn0, dn1;
  } exp_t;

  exp_t q[$];
  exp_t me;
  mdl_t m[2];
  int   n_cmp = 0, n_bad = 0;
  bit   start_req[2], hold[2], noise[2], lat_chk[2], pb[2];
  int   kick_ph[2], kick_left[2], model_done[2], dut_done[2], bstart[2];
  int   cyc = 0, lat_seen = 0;

  function automatic int p_n(int i);  return (i == 0) ? N0  : N1;  endfunction
  function automatic int p_lo(int i); return (i == 0) ? LO0 : LO1; endfunction
  function automatic int p_hi(int i); return (i == 0) ? HI0 : HI1; endfunction
  function automatic int p_dv(int i); return (i == 0) ? DV0 : DV1; endfunction

  function automatic int exp_lat(int i);
    return (p_n(i) + (p_n(i) - p_lo(i)) + (p_hi(i) - p_lo(i)) + p_hi(i)
            + 2 * p_lo(i)) * p_dv(i);
  endfunction

  function automatic int tgt(int ph, int i);
    case (ph)
      1: return p_n(i);
      2: return p_lo(i);
      3: return p_hi(i);
      5: return p_lo(i);
      default: return 0;
    endcase
  endfunction

  function automatic bit rising(int ph);
    return (ph == 1) || (ph == 3) || (ph == 5);
  endfunction

  function automatic logic [63:0] therm_m(int lvl);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) if (k < lvl) r[k] = 1'b1;
    return r;
  endfunction

  // One clock edge of the reference behaviour.
  function automatic mdl_t mstep(mdl_t cur, int i, bit r, bit f);
    mdl_t nx;
    bit fe, tk;
    nx = cur;
    nx.done = 1'b0;
    if (!r) begin
      nx.ph = 0; nx.lvl = 0; nx.cnt = 0; nx.s1 = 1'b0; nx.s2 = 1'b0;
      return nx;
    end
    fe = (LAT == 2) ? cur.s2 : f;
    nx.s2 = cur.s1;
    nx.s1 = f;
    if (cur.ph == 0) begin
      nx.cnt = 0;
      if (fe) begin nx.ph = 1; nx.lvl = 0; end
    end else begin
      tk = (cur.cnt == p_dv(i) - 1);
      nx.cnt = tk ? 0 : cur.cnt + 1;
      if (tk) begin
        nx.lvl = cur.lvl + (rising(cur.ph) ? 1 : -1);
        if (nx.lvl == tgt(cur.ph, i)) begin
          if (!rising(cur.ph) && fe) begin
            nx.ph = cur.ph - 1;
          end else begin
            nx.ph   = (cur.ph == 6) ? 0 : cur.ph + 1;
            nx.done = (cur.ph == 6);
          end
        end
      end
    end
    return nx;
  endfunction

  // Descending phase whose arrival tick is the next edge, else 0.
  function automatic int arr(mdl_t cur, int i);
    if (!rising(cur.ph) && cur.ph != 0 && cur.cnt == p_dv(i) - 1
        && cur.lvl - 1 == tgt(cur.ph, i))
      return cur.ph;
    return 0;
  endfunction

  // Model state at the edge a flick driven now will first influence.
  function automatic mdl_t look(mdl_t cur, int i);
    mdl_t l;
    l = cur;
    for (int k = 0; k < LAT; k++) l = mstep(l, i, 1'b1, 1'b0);
    return l;
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%0h want=%0h", tag, $time, got, want);
    end
  endtask

  task automatic step(input bit r);
    bit   f[2];
    mdl_t l;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      l = look(m[i], i);
      f[i] = 1'b0;
      if (start_req[i] || hold[i]) begin
        f[i] = 1'b1;
      end else if (kick_left[i] > 0 && kick_ph[i] != 0 && arr(l, i) == kick_ph[i]) begin
        f[i] = 1'b1;
        kick_left[i]--;
      end else if (noise[i] && l.ph != 0 && arr(l, i) == 0
                   && $urandom_range(0, 3) == 0) begin
        f[i] = 1'b1;
      end
      start_req[i] = 1'b0;
      m[i] = mstep(m[i], i, r, f[i]);
      if (m[i].done) model_done[i]++;
    end
    rst_n = r;
    fl0 = f[0];
    fl1 = f[1];
    e.led0 = therm_m(m[0].lvl) & ((64'd1 << N0) - 64'd1);
    e.led1 = therm_m(m[1].lvl) & ((64'd1 << N1) - 64'd1);
    e.st0 = 64'(m[0].ph);
    e.st1 = 64'(m[1].ph);
    e.bz0 = 64'(m[0].ph != 0);
    e.bz1 = 64'(m[1].ph != 0);
    e.dn0 = 64'(m[0].done);
    e.dn1 = 64'(m[1].done);
    q.push_back(e);
  endtask

  task automatic run(input int maxc);
    int c;
    c = 0;
    do begin
      step(1'b1);
      c++;
    end while ((c < 6 || m[0].ph != 0 || m[1].ph != 0) && c < maxc);
    check("run_idle", 64'(m[0].ph + m[1].ph), 64'd0);
  endtask

  task automatic track(input int i, input logic bz, input logic dn);
    if (bz === 1'b1 && !pb[i]) bstart[i] = cyc;
    if (dn === 1'b1) begin
      dut_done[i]++;
      if (lat_chk[i]) begin
        check(i == 0 ? "lat0" : "lat1", 64'(cyc - bstart[i]), 64'(exp_lat(i)));
        lat_chk[i] = 1'b0;
        lat_seen++;
      end
    end
    pb[i] = (bz === 1'b1);
  endtask

  // Monitor: compare DUT outputs against the oldest pushed expectation.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() > 0) begin
      me = q.pop_front();
      check("led0",  64'(led0), me.led0);
      check("state0", 64'(st0), me.st0);
      check("busy0", 64'(bz0),  me.bz0);
      check("done0", 64'(dn0),  me.dn0);
      check("led1",  64'(led1), me.led1);
      check("state1", 64'(st1), me.st1);
      check("busy1", 64'(bz1),  me.bz1);
      check("done1", 64'(dn1),  me.dn1);
      track(0, bz0, dn0);
      track(1, bz1, dn1);
    end
  end

  initial begin
    int c;
    for (int i = 0; i < 2; i++) begin
      m[i] = '{default: 0};
      start_req[i] = 1'b0; hold[i] = 1'b0; noise[i] = 1'b0;
      lat_chk[i] = 1'b0; pb[i] = 1'b0;
      kick_ph[i] = 0; kick_left[i] = 0;
      model_done[i] = 0; dut_done[i] = 0; bstart[i] = 0;
    end

    repeat (3) step(1'b0);
    repeat (3) step(1'b1);

    // Plain sequences; the small instance sees flick noise away from arrivals.
    start_req = '{1'b1, 1'b1};
    lat_chk   = '{1'b1, 1'b1};
    noise[1]  = 1'b1;
    run(400);
    noise[1]  = 1'b0;

    // Kickback at P_LO (large) and at the DOWN_ZERO floor (small).
    start_req = '{1'b1, 1'b1};
    kick_ph = '{2, 4}; kick_left = '{1, 1};
    run(400);

    // Kickback at the DOWN_ZERO floor (large) and DOWN_FIN floor (small).
    start_req = '{1'b1, 1'b1};
    kick_ph = '{4, 6}; kick_left = '{1, 1};
    run(400);

    // Repeated DOWN_FIN kickbacks (large) and repeated P_LO kickbacks (small).
    start_req = '{1'b1, 1'b1};
    kick_ph = '{6, 2}; kick_left = '{2, 2};
    run(600);

    // flick held high: DOWN_P1 <-> UP_FULL loop, no done until released.
    hold[0] = 1'b1;
    start_req[1] = 1'b1;
    repeat (70) step(1'b1);
    hold[0] = 1'b0;
    run(600);

    // Reset mid-sequence at level 9.
    start_req = '{1'b1, 1'b1};
    c = 0;
    do begin
      step(1'b1);
      c++;
    end while (!(m[0].ph == 1 && m[0].lvl == 9) && c < 60);
    check("lvl9_reached", 64'(m[0].lvl), 64'd9);
    step(1'b0);
    step(1'b0);
    repeat (4) step(1'b1);

    @(posedge clk);
    #2;
    check("done_cnt0", 64'(dut_done[0]), 64'(model_done[0]));
    check("done_cnt1", 64'(dut_done[1]), 64'(model_done[1]));
    check("lat_seen", 64'(lat_seen), 64'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_bounce_ctrl.md
Name: led_bounce_ctrl

Overview:
- Parametrised successor to the team's 16-LED flash/bounce lab controller.
- Drives an N-wide thermometer LED bar through a six-phase rise/fall sequence with `flick`-driven kickback at the low turn points.
- Adds a step-rate prescaler, configurable turn points, and `busy`/`done`/`state` status outputs.
- Sits between the board push-button/`flick` input and the LED pins.

Parameters:
- N, 16, number of LEDs; 4 ≤ N ≤ 64.
- P_LO, 5, low turn level; 0 < P_LO < P_HI.
- P_HI, 10, high turn level; P_HI < N.
- TICK_DIV, 1, clocks per LED step; 1 means step every clock; ≥ 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flick  in  1  start/kickback request, level-sensitive.
- led  out  N  thermometer bar: `led = (1<<level)-1`, lit from bit 0.
- state  out  3  current phase encoding (debug).
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-clock pulse on the return to IDLE.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - level = 0, led = 0, state = IDLE, busy = 0, done = 0.
  - Prescaler = 0; synchroniser flops = 0.
  - Reset mid-sequence aborts immediately; no partial outputs are held.
- Level and width:
  - level is an internal counter of width `$clog2(N+1)`, range 0..N.
  - All outputs are registered.
- Prescaler:
  - Counts 0..TICK_DIV-1 while busy; `tick = (cnt == TICK_DIV-1)`.
  - Held at 0 in IDLE.
- IDLE:
  - flick is sampled every clock, not gated by tick.
  - flick = 1 → next cycle state = UP_FULL, level = 0, prescaler = 0.
- Stepping:
  - Steps occur only on tick cycles.
  - Ascending phase: `level+1`. Descending phase: `level-1`.
  - When the stepped value equals the phase target, the state change happens on the same edge.
- Phases (target → next):
  - UP_FULL: 0 → N, then DOWN_P1.
  - DOWN_P1: N → P_LO. At arrival: flick = 1 → UP_FULL (kickback); else → UP_P2.
  - UP_P2: P_LO → P_HI (or 0 → P_HI after a kickback), then DOWN_ZERO.
  - DOWN_ZERO: P_HI → 0. At arrival: flick = 1 → UP_P2 (kickback); else → UP_P3.
  - UP_P3: 0 → P_LO, then DOWN_FIN.
  - DOWN_FIN: P_LO → 0. At arrival: flick = 1 → UP_P3 (kickback); else → IDLE with done = 1 for one clock.
- Kickback sampling: flick is evaluated only on the arrival tick of a descending phase; at all other times flick is ignored while busy.
- Kickback target: jumps to the preceding ascending phase; level continues from its current value, with no reset of level.
- flick held high continuously: DOWN_P1 ↔ UP_FULL repeats indefinitely. This is legal; busy stays 1 and done never fires.
- Nominal sequence length (no kickback): N + (N-P_LO) + (P_HI-P_LO) + P_HI + 2·P_LO ticks. For the defaults this is 52 ticks.
- Illegal state encodings → IDLE on the next clock.

Optional Feature:
- Macro: LED_BOUNCE_FLICK_SYNC_EN.
- Defined: flick passes a 2-flop synchroniser before all use. Every flick-related response is delayed by exactly 2 clocks, and the kickback decision uses the synchronised value.
- Undefined: flick is used directly; the bench drives it synchronously to clk.

Decomposition:
- Package led_bounce_pkg holds:
  - State enum typedef: IDLE=0, UP_FULL=1, DOWN_P1=2, UP_P2=3, DOWN_ZERO=4, UP_P3=5, DOWN_FIN=6.
  - Function `therm(level)` returning the N-bit thermometer code.
- Sub-module led_tick_gen (parameter TICK_DIV; ports clk, rst_n, en, tick) holds the prescaler.
- The FSM and level counter stay in the top module.

Test Plan:
- Reset: assert rst_n = 0 for 2 clocks mid-sequence at level 9 → next edge gives led = 0x0000, state = 0, busy = 0; no done pulse.
- Full sequence, defaults, TICK_DIV = 1: 1-clock flick pulse in IDLE at cycle t →
  - state = UP_FULL at t+1; led = 0x0001 at t+2; led = 0xFFFF at t+17.
  - led = 0x001F after 11 further ticks, then rises to 0x03FF.
  - Reaches 0 at the end of DOWN_ZERO.
  - done pulses once, 52 ticks after the first step; led = 0 and busy = 0 afterwards.
- Kickback at P_LO: flick high on the DOWN_P1 arrival tick (led = 0x001F) → next state UP_FULL; led steps 0x003F … 0xFFFF.
- Kickback at 0: flick high on the DOWN_ZERO arrival tick → UP_P2 from 0, led rises to 0x03FF; similarly DOWN_FIN with flick → UP_P3.
- Prescaler and parameters: TICK_DIV = 4, N = 8, P_LO = 2, P_HI = 5 → led changes exactly every 4 clocks; sequence of 8+6+3+5+4 = 26 ticks = 104 clocks to done; flick pulses while busy and not on an arrival tick have no effect.
- LED_BOUNCE_FLICK_SYNC_EN defined: repeat the full-sequence and kickback-at-P_LO scenarios with flick raised 2 clocks earlier → identical led trace; a 1-clock flick pulse in IDLE still starts the sequence, 2 clocks later than without the macro.
